// File: rtl/regfile_operand_fetch.sv
// Operand-fetch front end for a 16x32 register file with one write port and two read ports.
// Writebacks pass straight through; reads are issued only on write-free cycles, and the operands come back over valid/ready.
module regfile_operand_fetch #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data_a,
    output logic [DATA_WIDTH-1:0] resp_data_b,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_a,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_b,
    input  logic [DATA_WIDTH-1:0] rf_read_data_a,
    input  logic [DATA_WIDTH-1:0] rf_read_data_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_req_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [DATA_WIDTH-1:0] r_data_b;

    assign rf_write       = wb_valid;
    assign rf_write_addr  = wb_addr;
    assign rf_write_data  = wb_data;
    assign rf_read_addr_a = req_addr_a;
    assign rf_read_addr_b = req_addr_b;

    // The file ignores reads on write cycles, so any writeback blocks issue.
    assign w_req_ready = !wb_valid &&
                         ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
    assign w_accept    = req_valid && w_req_ready;

    assign req_ready   = w_req_ready;
    assign resp_valid  = reset && (r_state == RESP);
    assign resp_data_a = r_data_a;
    assign resp_data_b = r_data_b;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_next = w_accept ? FETCH : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read data from the file is valid only during FETCH; hold it until the handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (r_state == FETCH) begin
            r_data_a <= rf_read_data_a;
            r_data_b <= rf_read_data_b;
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: a behavioural 16x32 register file plus a queue of expected operands.
// Each accepted request pushes its expected operands onto the queue, and each response handshake pops and compares them.
module tb_regfile_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr_a;
    logic [3:0]  req_addr_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data_a;
    logic [31:0] resp_data_b;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_write;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [3:0]  rf_read_addr_a;
    logic [3:0]  rf_read_addr_b;
    logic [31:0] rf_read_data_a;
    logic [31:0] rf_read_data_b;

    always #5 clk = ~clk;

    regfile_operand_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr_a     (req_addr_a),
        .req_addr_b     (req_addr_b),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data_a    (resp_data_a),
        .resp_data_b    (resp_data_b),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rf_write       (rf_write),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_addr_a (rf_read_addr_a),
        .rf_read_addr_b (rf_read_addr_b),
        .rf_read_data_a (rf_read_data_a),
        .rf_read_data_b (rf_read_data_b)
    );

    // Register file: reads sampled only on write-free cycles, data one clock later, reg 0 reads 0.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rf_write) begin
            if (rf_write_addr != 4'd0) mem[rf_write_addr] <= rf_write_data;
        end else begin
            rf_read_data_a <= mem[rf_read_addr_a];
            rf_read_data_b <= mem[rf_read_addr_b];
        end
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        int          c;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] model [16];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          acc_now, hs_now, resp_seen;
    int          last_acc, last_hs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with inputs already set; returns just after the next edge.
    task automatic cycle();
        #1;
        acc_now = req_valid && req_ready;
        hs_now  = resp_valid && resp_ready;
        if (resp_valid && !resp_seen) begin
            resp_seen = 1'b1;
            if (sbq.size() == 0) chk1("spurious_resp", resp_valid, 1'b0);
            else chk("latency", cyc - sbq[0].c, 2);
        end
        if (hs_now) begin
            last_hs   = cyc;
            resp_seen = 1'b0;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("resp_data_a", resp_data_a, e.a);
                chk("resp_data_b", resp_data_b, e.b);
            end
        end
        if (acc_now) begin
            last_acc = cyc;
            sbq.push_back('{model[req_addr_a], model[req_addr_b], cyc});
        end
        if (wb_valid && wb_addr != 4'd0) model[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_accept(input int maxc);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_now && n < maxc);
        chk1("accept_timeout", acc_now, 1'b1);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sbq.size() > 0 && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, h1, n;
        bit hs_at_a2;
        for (int i = 0; i < 16; i++) begin
            mem[i]   = 32'd0;
            model[i] = 32'd0;
        end
        rf_read_data_a = 32'd0;
        rf_read_data_b = 32'd0;
        reset = 1'b0; req_valid = 1'b0; req_addr_a = 4'd0; req_addr_b = 4'd0;
        resp_ready = 1'b0; wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
        @(posedge clk); #1;

        // Reset held low, then released.
        cycle();
        chk1("rst_resp_valid_low", resp_valid, 1'b0);
        cycle();
        reset = 1'b1;
        #1;
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rf_write", rf_write, 1'b0);
        chk("rst_resp_data_a", resp_data_a, 32'd0);

        // Writeback then read of reg 5 and reg 0.
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
        #1;
        chk1("wb_rf_write", rf_write, 1'b1);
        chk("wb_rf_addr", 32'(rf_write_addr), 32'd5);
        chk("wb_rf_data", rf_write_data, 32'hDEADBEEF);
        cycle();
        wb_valid = 1'b0;
        req_valid = 1'b1; req_addr_a = 4'd5; req_addr_b = 4'd0; resp_ready = 1'b1;
        wait_accept(4);
        req_valid = 1'b0;
        drain(8);

        // Writebacks stall acceptance for three cycles.
        req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd4;
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1;
            wb_addr  = (k == 0) ? 4'd3 : (k == 1) ? 4'd4 : 4'd7;
            wb_data  = 32'hC0DE0000 | 32'(wb_addr);
            #1;
            chk1("stall_req_ready", req_ready, 1'b0);
            chk1("stall_rf_write", rf_write, 1'b1);
            chk("stall_rf_addr", 32'(rf_write_addr), 32'(wb_addr));
            chk("stall_rf_data", rf_write_data, 32'hC0DE0000 | 32'(wb_addr));
            cycle();
        end
        wb_valid = 1'b0;
        #1;
        chk1("stall_release_ready", req_ready, 1'b1);
        chk1("stall_release_wr", rf_write, 1'b0);
        cycle();
        chk1("stall_accepted", acc_now, 1'b1);
        req_valid = 1'b0;
        drain(8);

        // Response held under backpressure while reg 5 is overwritten.
        req_valid = 1'b1; req_addr_a = 4'd5; req_addr_b = 4'd3; resp_ready = 1'b0;
        wait_accept(4);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 6) begin
            cycle();
            n++;
        end
        chk1("hold_resp_valid_rise", resp_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wb_valid = (k == 0);
            wb_addr = 4'd5; wb_data = 32'h12345678;
            #1;
            chk1("hold_resp_valid", resp_valid, 1'b1);
            chk("hold_data_a", resp_data_a, 32'hDEADBEEF);
            cycle();
        end
        wb_valid = 1'b0;
        resp_ready = 1'b1;
        drain(4);
        req_valid = 1'b1; req_addr_a = 4'd5; req_addr_b = 4'd0;
        wait_accept(4);
        req_valid = 1'b0;
        drain(8);

        // Writeback during FETCH must not disturb the captured operand.
        req_valid = 1'b1; req_addr_a = 4'd6; req_addr_b = 4'd7;
        wait_accept(4);
        req_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'h66666666;
        cycle();
        wb_valid = 1'b0;
        drain(8);

        // Back-to-back requests: second accepted in the handshake cycle.
        req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd4;
        wait_accept(4);
        a1 = last_acc;
        req_addr_a = 4'd6; req_addr_b = 4'd7;
        wait_accept(6);
        a2 = last_acc;
        hs_at_a2 = hs_now;
        h1 = last_hs;
        chk1("b2b_accept_in_handshake", hs_at_a2, 1'b1);
        chk("b2b_accept_spacing", a2 - a1, 2);
        req_valid = 1'b0;
        drain(8);
        chk("b2b_resp_spacing", last_hs - h1, 2);

        // Reset during FETCH drops the request.
        req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd4;
        wait_accept(4);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk1("fetch_rst_resp_valid", resp_valid, 1'b0);
        cycle();
        sbq.delete();
        resp_seen = 1'b0;
        reset = 1'b1;
        #1;
        chk1("post_rst_resp_valid", resp_valid, 1'b0);
        chk1("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_data_a", resp_data_a, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk1("dropped_no_resp", resp_valid, 1'b0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
Requester-side front end for the 16x32 register file. Accepts two-operand read requests from decode and writeback commits from the execute/retire stage. Drives the register file's single write port and dual read ports, and sequences the file's rules: a read is only sampled on a cycle with no write, and read data appears one clock later. Returns captured operands to decode over a valid/ready response channel.

Parameters:
ADDR_WIDTH, 4, register address width
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  1  decode presents an operand-read request
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_addr_a  in  ADDR_WIDTH  source register A
req_addr_b  in  ADDR_WIDTH  source register B
resp_valid  out  1  resp_data_a/b hold operands for the last accepted request
resp_ready  in  1  decode consumes the response
resp_data_a  out  DATA_WIDTH  operand A
resp_data_b  out  DATA_WIDTH  operand B
wb_valid  in  1  writeback commit; always accepted, no backpressure
wb_addr  in  ADDR_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback value
rf_write  out  1  to register file write
rf_write_addr  out  ADDR_WIDTH  to register file write_addr
rf_write_data  out  DATA_WIDTH  to register file write_data
rf_read_addr_a  out  ADDR_WIDTH  to register file read_addr_a
rf_read_addr_b  out  ADDR_WIDTH  to register file read_addr_b
rf_read_data_a  in  DATA_WIDTH  from register file read_data_a
rf_read_data_b  in  DATA_WIDTH  from register file read_data_b

Behaviour:
- Write path is combinational: rf_write = wb_valid, rf_write_addr = wb_addr, rf_write_data = wb_data. wb_addr 0 is passed through; the file discards it.
- FSM states: IDLE, FETCH, RESP. Reset value is IDLE. While reset = 0, resp_valid = 0, resp_data_a/b = 0, and any pending request is dropped.
- req_ready = wb_valid == 0 && (state == IDLE || (state == RESP && resp_ready)). A writeback always stalls request acceptance, because the file ignores reads on write cycles.
- rf_read_addr_a/b = req_addr_a/b combinationally, in every state.
- IDLE: on accept, go to FETCH. Otherwise stay in IDLE.
- FETCH: rf_read_data_a/b are valid this cycle. Register them into resp_data_a/b at the cycle's end and go to RESP. A wb_valid in FETCH does not corrupt the captured data. The captured data reflects register contents before that write.
- RESP: resp_valid = 1 and resp_data is stable until the handshake.
  - On resp_ready with an accepted new request: go to FETCH.
  - On resp_ready with no new request: go to IDLE.
  - Without resp_ready: stay in RESP.
- Latency from accept cycle N: resp_valid rises at N+2. Sustained throughput is one request per 2 cycles with no writebacks.
- Operand ordering: a writeback committed at or before the accept cycle's preceding edge is visible. A writeback in the accept cycle itself blocks the accept, so no stale read is possible at issue.
- Address 0 reads return 0, as guaranteed by the file. The block does no special-casing.
- Reset asserted in any state: next state is IDLE, and resp_valid is 0 on the following cycle.

Test Plan:
- Reset low 2 cycles, then high → resp_valid = 0, req_ready = 1, rf_write = 0.
- wb (addr 5, 0xDEADBEEF), then req a=5 b=0 with resp_ready = 1 → resp_valid two cycles after accept; data_a = 0xDEADBEEF, data_b = 0.
- req_valid and wb_valid both high for 3 cycles → req_ready = 0 for those 3 cycles. Accept occurs on the first cycle with wb_valid = 0. rf_write pulses 3 times with correct addr/data.
- Response held with resp_ready = 0 for 4 cycles while wb (addr 5, 0x12345678) commits → resp_data_a stays 0xDEADBEEF. A later request of reg 5 returns 0x12345678.
- Back-to-back requests (3,4), then (6,7) with resp_ready = 1 → second request accepted in the RESP-handshake cycle. Responses are 2 cycles apart with correct values.
- Reset low during FETCH → next cycle state IDLE, resp_valid = 0, and no response is ever issued for the dropped request.
